// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, drives imem, feeds IF/ID with PC/NPC/instr; RUN/BR_WAIT/HALTED FSM.
// Latency: PC/state registered, instr combinational from state and imem_rdata (zero cycles).
// Backpressure: reg_detect_confict holds PC and re-presents the same word; BR_WAIT emits NOPs until resolved.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] NPC,
    output logic [31:0] instr,
    input  logic        reg_detect_confict,
    input  logic        PC_bobl,
    input  logic        JPC_en,
    input  logic [31:0] JPC,
    input  logic        halt,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [1:0]  state,
    output logic [31:0] fetch_cnt,
    output logic [15:0] bubble_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        BR_WAIT = 2'b01,
        HALTED  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_q;
    logic [15:0] bubble_q;
    logic [31:0] pc_plus4;
    logic        advance;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        advance = 1'b0;
        case (state_q)
            RUN: begin
                // halt outranks a stall; a stall masks every other control
                if (halt) begin
                    state_d = HALTED;
                end else if (reg_detect_confict) begin
                    pc_d = pc_q;
                end else if (PC_bobl) begin
                    pc_d    = pc_plus4;
                    state_d = BR_WAIT;
                    advance = 1'b1;
                end else if (JPC_en) begin
                    pc_d    = JPC;
                    advance = 1'b1;
                end else begin
                    pc_d    = pc_plus4;
                    advance = 1'b1;
                end
            end
            BR_WAIT: begin
                // PC already points at branch+4, so not-taken simply resumes here
                if (br_valid && !reg_detect_confict) begin
                    pc_d    = br_taken ? br_target : pc_q;
                    state_d = RUN;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            fetch_q  <= 32'd0;
            bubble_q <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (advance) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (state_q == BR_WAIT && bubble_q != 16'hFFFF) begin
                bubble_q <= bubble_q + 16'd1;
            end
        end
    end

    assign imem_addr  = pc_q;
    assign PC         = pc_q;
    assign NPC        = pc_plus4;
    assign instr      = (state_q == RUN) ? imem_rdata : 32'h0;
    assign state      = state_q;
    assign fetch_cnt  = fetch_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        reg_detect_confict, PC_bobl, JPC_en, halt, br_valid, br_taken;
    logic [31:0] JPC, br_target;

    logic [31:0] imem_addr, imem_rdata, pc, npc, instr, fetch_cnt;
    logic [1:0]  state;
    logic [15:0] bubble_cnt;

    logic [31:0] w_addr, w_rdata, w_pc, w_npc, w_instr, w_fetch;
    logic [1:0]  w_state;
    logic [15:0] w_bubble;

    // Memory model: each word is the bitwise inverse of its address
    assign imem_rdata = ~imem_addr;
    assign w_rdata    = ~w_addr;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .PC(pc), .NPC(npc), .instr(instr), .reg_detect_confict(reg_detect_confict),
        .PC_bobl(PC_bobl), .JPC_en(JPC_en), .JPC(JPC), .halt(halt),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .state(state), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .PC(w_pc), .NPC(w_npc), .instr(w_instr), .reg_detect_confict(reg_detect_confict),
        .PC_bobl(PC_bobl), .JPC_en(JPC_en), .JPC(JPC), .halt(halt),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .state(w_state), .fetch_cnt(w_fetch), .bubble_cnt(w_bubble)
    );

    localparam logic [1:0] S_RUN = 2'b00, S_BW = 2'b01, S_HLT = 2'b10;

    typedef struct {
        logic        rst, stall, bobl, jen;
        logic [31:0] jpc;
        logic        hlt, brv, brt;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic [31:0] e_fc;
        logic [15:0] e_bc;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic rst, logic stall, logic bobl, logic jen, logic [31:0] jpc,
                                logic hlt, logic brv, logic brt, logic [31:0] tgt,
                                logic [31:0] e_pc, logic [1:0] e_st, logic [31:0] e_fc, logic [15:0] e_bc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.bobl = bobl; v.jen = jen; v.jpc = jpc;
        v.hlt = hlt; v.brv = brv; v.brt = brt; v.tgt = tgt;
        v.e_pc = e_pc; v.e_st = e_st; v.e_fc = e_fc; v.e_bc = e_bc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        reg_detect_confict = 0; PC_bobl = 0; JPC_en = 0; JPC = 0;
        halt = 0; br_valid = 0; br_taken = 0; br_target = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [1:0] e_st,
                           input logic [31:0] e_fc, input logic [15:0] e_bc);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".addr"}, imem_addr, e_pc);
        chk({tag, ".npc"}, npc, e_pc + 32'd4);
        chk({tag, ".state"}, {30'd0, state}, {30'd0, e_st});
        chk({tag, ".instr"}, instr, (e_st == S_RUN) ? ~e_pc : 32'h0);
        chk({tag, ".fetch"}, fetch_cnt, e_fc);
        chk({tag, ".bubble"}, {16'd0, bubble_cnt}, {16'd0, e_bc});
    endtask

    initial begin
        idle();
        reset = 0;
        step();
        chk_all("reset", 32'h0, S_RUN, 0, 0);
        chk("wrap.pc_reset", w_pc, 32'hFFFF_FFFC);
        chk("wrap.npc_reset", w_npc, 32'h0);
        reset = 1;
        step();
        chk("wrap.pc_next", w_pc, 32'h0);
        chk("wrap.npc_next", w_npc, 32'h4);

        //         rst st bo jn jpc          h  bv bt tgt          e_pc     e_st   fc bc
        // sequential
        vq.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h00, S_RUN, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h04, S_RUN, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h08, S_RUN, 2, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0C, S_RUN, 3, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h10, S_RUN, 4, 0));
        // stall at 8 masks branch and jump
        vq.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h00, S_RUN, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h04, S_RUN, 1, 0));
        vq.push_back(mk(0, 1, 1, 0, 32'h0,   0, 0, 0, 32'h0,  32'h08, S_RUN, 2, 0));
        vq.push_back(mk(0, 1, 0, 1, 32'h100, 0, 0, 0, 32'h0,  32'h08, S_RUN, 2, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h08, S_RUN, 2, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0C, S_RUN, 3, 0));
        // taken branch, jump ignored while waiting
        vq.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h00, S_RUN, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h04, S_RUN, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 32'h0,   0, 0, 0, 32'h0,  32'h08, S_RUN, 2, 0));
        vq.push_back(mk(0, 0, 0, 1, 32'h200, 0, 0, 0, 32'h0,  32'h0C, S_BW,  3, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0C, S_BW,  3, 1));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 1, 1, 32'h20, 32'h0C, S_BW,  3, 2));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h20, S_RUN, 3, 3));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h24, S_RUN, 4, 3));
        // not-taken branch, first resolution stalled
        vq.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h00, S_RUN, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h04, S_RUN, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 32'h0,   0, 0, 0, 32'h0,  32'h08, S_RUN, 2, 0));
        vq.push_back(mk(0, 1, 0, 0, 32'h0,   0, 1, 1, 32'h80, 32'h0C, S_BW,  3, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 1, 0, 32'h80, 32'h0C, S_BW,  3, 1));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0C, S_RUN, 3, 2));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h10, S_RUN, 4, 2));
        // jump then halt (halt beats a simultaneous stall)
        vq.push_back(mk(1, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h00, S_RUN, 0, 0));
        vq.push_back(mk(0, 0, 0, 1, 32'h40,  0, 0, 0, 32'h0,  32'h04, S_RUN, 1, 0));
        vq.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h40, S_RUN, 2, 0));
        vq.push_back(mk(0, 1, 0, 0, 32'h0,   1, 0, 0, 32'h0,  32'h44, S_RUN, 3, 0));
        vq.push_back(mk(0, 0, 1, 1, 32'h300, 0, 1, 1, 32'h90, 32'h44, S_HLT, 3, 0));

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst) begin
                reset = 0;
                #1;
                reset = 1;
            end
            reg_detect_confict = vq[i].stall; PC_bobl = vq[i].bobl; JPC_en = vq[i].jen;
            JPC = vq[i].jpc; halt = vq[i].hlt; br_valid = vq[i].brv;
            br_taken = vq[i].brt; br_target = vq[i].tgt;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_st, vq[i].e_fc, vq[i].e_bc);
            step();
        end

        // HALTED is sticky for ten cycles with noisy inputs
        JPC_en = 1; JPC = 32'h500; PC_bobl = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_all($sformatf("halted%0d", i), 32'h44, S_HLT, 3, 0);
            step();
        end
        idle();

        // async reset mid-cycle out of HALTED
        #2 reset = 0;
        #1 chk_all("arst_halt", 32'h0, S_RUN, 0, 0);
        #1 reset = 1;
        step();
        @(negedge clk);
        chk_all("after_arst", 32'h4, S_RUN, 1, 0);
        step();

        // bubble_cnt saturation in a long BR_WAIT
        reset = 0; #1 reset = 1;
        step(); step();
        PC_bobl = 1;
        step();
        PC_bobl = 0;
        repeat (70000) step();
        @(negedge clk);
        chk_all("saturate", 32'h0C, S_BW, 3, 16'hFFFF);
        step();
        chk("saturate_hold", {16'd0, bubble_cnt}, 32'h0000_FFFF);

        // async reset mid-BR_WAIT aborts the wait
        #2 reset = 0;
        #1 chk_all("arst_bw", 32'h0, S_RUN, 0, 0);
        #1 reset = 1;
        step();
        @(negedge clk);
        chk_all("after_arst_bw", 32'h4, S_RUN, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that drives the IF/ID pipeline register: it owns the program counter, presents the fetch address to instruction memory, and forwards PC, NPC and the fetched instruction downstream. It consumes the control signals IF/ID decodes from the instruction it just fetched: branch bubble request, jump, halt and load-use stall. Branches are resolved externally and the result is fed back to this block. The block includes a small three-state control FSM and two performance counters.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- imem_addr  output  32  instruction memory address (= pc_reg)
- imem_rdata  input  32  instruction word at imem_addr, combinational read
- PC  output  32  address of instruction presented on instr
- NPC  output  32  PC + 4, modulo 2^32
- instr  output  32  imem_rdata in RUN, 32'h0 (NOP) otherwise
- reg_detect_confict  input  1  load-use stall; hold PC
- PC_bobl  input  1  instr is beq/bne; enter branch wait
- JPC_en  input  1  unconditional jump request
- JPC  input  32  jump target
- halt  input  1  instr is the halt word
- br_valid  input  1  branch resolution valid (sampled only in BR_WAIT)
- br_taken  input  1  branch taken
- br_target  input  32  taken-branch target
- state  output  2  00 RUN, 01 BR_WAIT, 10 HALTED
- fetch_cnt  output  32  instructions issued, wraps
- bubble_cnt  output  16  BR_WAIT cycles, saturates at 16'hFFFF

## Operation
- The FSM has three states: RUN, BR_WAIT and HALTED. All PC, state and counter registers update on posedge clk.
- RUN: the next-PC priority is as follows.
  - halt=1: PC holds; go to HALTED.
  - reg_detect_confict=1: PC holds. PC_bobl, JPC_en and halt are ignored this cycle.
  - PC_bobl=1: PC <= PC+4; go to BR_WAIT.
  - JPC_en=1: PC <= JPC.
  - Otherwise: PC <= PC+4.
- halt has priority over a stall. In the stall case the IF/ID register holds too, so the same word is re-presented next cycle.
- PC_bobl and JPC_en are mutually exclusive by decode. If both are high, PC_bobl wins.
- BR_WAIT: instr = 0, so PC_bobl and halt read 0.
  - br_valid=1 and reg_detect_confict=0: PC <= br_taken ? br_target : PC (PC already holds branch+4); go to RUN.
  - br_valid while reg_detect_confict=1 is ignored; remain in BR_WAIT.
  - JPC_en is ignored.
- HALTED: instr = 0 and PC holds. The state is sticky and is left only by reset. All inputs are ignored.
- fetch_cnt increments on each edge where state=RUN and the PC advances (no stall, no halt). It wraps at 2^32.
- bubble_cnt increments on each edge spent in BR_WAIT and saturates at 16'hFFFF.
- No alignment check is made. Targets are used as given, and bits [1:0] are passed through.

## Timing
- Reset (asynchronous, reset=0) forces:
  - pc_reg=RESET_PC, state=RUN, fetch_cnt=0, bubble_cnt=0.
  - Therefore imem_addr=PC=RESET_PC, NPC=RESET_PC+4, instr=imem_rdata.
- Reset asserted mid-BR_WAIT or in HALTED aborts immediately. The first fetch after release is at RESET_PC, on the first rising edge with reset=1.
- PC, NPC, imem_addr and state are register outputs. instr is combinational from state and imem_rdata, with zero latency.
- Branch penalty: beq fetched in cycle n. Cycles n+1 through n+k are NOPs while waiting, where br_valid is first seen in cycle n+k. The resolved PC is presented in cycle n+k+1.
- Jump: JPC_en in cycle n, target presented in cycle n+1, zero bubbles.
- Wraparound: at PC=32'hFFFF_FFFC, NPC = 32'h0000_0000 and sequential fetch wraps to 0.

## Test plan
- Reset/sequential: release reset with RESET_PC=0 and no control inputs for 4 cycles. PC must read 0,4,8,C; fetch_cnt must read 4; state must stay RUN.
- Stall: assert reg_detect_confict for 2 cycles at PC=8. PC must stay 8 for 3 cycles then advance to C; fetch_cnt must not count the stalled cycles.
- Taken branch: PC_bobl at PC=8. PC must go to C with state=BR_WAIT and instr=0. Then br_valid=1, br_taken=1, br_target=20 two cycles later; PC must go to 20, state RUN, bubble_cnt=3.
- Not-taken branch and stalled resolution: PC_bobl at 8. br_valid=1 with reg_detect_confict=1 must be ignored. Then br_valid=1, br_taken=0; PC must continue at C.
- Jump then halt: JPC_en with JPC=40 at PC=4 must give PC=40 next cycle. halt at 44 must give state=HALTED, PC stuck at 44, instr=0 for 10 cycles. Async reset asserted mid-cycle must give PC=0 and state RUN immediately.
- Wraparound/saturation: RESET_PC=FFFF_FFFC must give NPC=0 and next PC=0. Holding BR_WAIT for 70000 cycles must leave bubble_cnt=FFFF.
